bkm_control_step_stim: RTL and testbench

//  Stimulus generator for the bkm_control_step verification bench; it is the producer side of the vector stream the checker consumes.

---
 rtl/bkm_control_step_stim_pkg.sv | 29 ++
 rtl/bkm_control_step_stim_if.sv | 26 ++
 rtl/bkm_control_step_stim_lfsr64_step.sv | 11 +
 rtl/bkm_control_step_stim.sv | 132 +++++++++++++
 tb/tb_bkm_control_step_stim.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/bkm_control_step_stim_pkg.sv
// Shared definitions for the BKM step stimulus generator: FSM states,
// digit encodings, LFSR tap constant and small helper functions.
package bkm_control_step_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] BKM_D_ZERO = 2'b00;
  localparam logic [1:0] BKM_D_POS  = 2'b01;
  localparam logic [1:0] BKM_D_NEG  = 2'b11;

  // Galois taps for x^64+x^63+x^61+x^60+1 (right-shifting form)
  localparam logic [63:0] LFSR_TAP = 64'hD800000000000000;

  // Raw 2'b10 has no digit meaning; it is folded onto zero.
  function automatic logic [1:0] legal_digit(input logic [1:0] raw);
    return (raw == 2'b10) ? BKM_D_ZERO : raw;
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [63:0] fix_seed(input logic [63:0] seed);
    return (seed == 64'd0) ? 64'd1 : seed;
  endfunction

endpackage

// File: rtl/bkm_control_step_stim_if.sv
// Vector stream between the stimulus generator (master) and the
// reference model / DUT consumers (slave).
interface bkm_control_step_stim_if #(
  parameter int W     = 64,
  parameter int LOG2N = 6
);
  logic             out_valid;
  logic             out_ready;
  logic             tb_mode;
  logic [1:0]       tb_format;
  logic [LOG2N-1:0] tb_n;
  logic [1:0]       tb_d_u_n;
  logic [1:0]       tb_d_v_n;
  logic [W-1:0]     tb_u_n;
  logic [W-1:0]     tb_v_n;

  modport master (
    output out_valid, tb_mode, tb_format, tb_n, tb_d_u_n, tb_d_v_n, tb_u_n, tb_v_n,
    input  out_ready
  );

  modport slave (
    input  out_valid, tb_mode, tb_format, tb_n, tb_d_u_n, tb_d_v_n, tb_u_n, tb_v_n,
    output out_ready
  );
endinterface

// File: rtl/bkm_control_step_stim_lfsr64_step.sv
// One combinational Galois step of the 64-bit operand LFSR.
module lfsr64_step
  import bkm_control_step_stim_pkg::*;
(
  input  logic [63:0] cur,
  output logic [63:0] nxt
);

  assign nxt = (cur >> 1) ^ (cur[0] ? LFSR_TAP : 64'd0);

endmodule

// File: rtl/bkm_control_step_stim.sv
// Stimulus generator: after start, emits N_VEC vectors over valid/ready
// with LFSR operands and a wrapping step index.
module bkm_control_step_stim
  import bkm_control_step_stim_pkg::*;
#(
  parameter int          W      = 64,
  parameter int          LOG2N  = 6,
  parameter int          N_VEC  = 1024,
  parameter logic [63:0] SEED_U = 64'h1,
  parameter logic [63:0] SEED_V = 64'h2
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         enable,
  input  logic                         start,
  input  logic                         cfg_mode,
  input  logic [1:0]                   cfg_format,
  input  logic [LOG2N-1:0]             cfg_n_last,
  bkm_control_step_stim_if.master      vec,
  output logic [31:0]                  vec_count,
  output logic                         busy,
  output logic                         done
);

  localparam logic [63:0] SEED_U_FIX = fix_seed(SEED_U);
  localparam logic [63:0] SEED_V_FIX = fix_seed(SEED_V);
  localparam logic [31:0] LAST_CNT   = 32'(N_VEC - 1);

  state_t           state_q, state_d;
  logic             accept_start;
  logic             xfer;
  logic             last_xfer;
  logic [63:0]      lfsr_u_q, lfsr_v_q;
  logic [63:0]      lfsr_u_nx, lfsr_v_nx;
  logic [LOG2N-1:0] n_last_q;

  lfsr64_step u_step_u (.cur(lfsr_u_q), .nxt(lfsr_u_nx));
  lfsr64_step u_step_v (.cur(lfsr_v_q), .nxt(lfsr_v_nx));

  assign xfer      = vec.out_valid & vec.out_ready;
  assign last_xfer = xfer & (vec_count == LAST_CNT);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_RUN);

  // Next-state logic; a start is only honoured when not busy.
  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_LOAD;
          accept_start = 1'b1;
        end
      end
      ST_LOAD: state_d = ST_RUN;
      ST_RUN:  if (last_xfer) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, frozen while enable is low.
  always_ff @(posedge clk or posedge arst) begin
    if (arst)        state_q <= ST_IDLE;
    else if (enable) state_q <= state_d;
  end

  // Operand LFSRs advance only when a vector is accepted; restarts continue.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      lfsr_u_q <= SEED_U_FIX;
      lfsr_v_q <= SEED_V_FIX;
    end else if (enable && xfer) begin
      lfsr_u_q <= lfsr_u_nx;
      lfsr_v_q <= lfsr_v_nx;
    end
  end

  // Run control: config latch, valid, accepted-vector count and done flag.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      vec.out_valid <= 1'b0;
      vec.tb_mode   <= 1'b0;
      vec.tb_format <= 2'b00;
      n_last_q      <= '0;
      vec_count     <= 32'd0;
      done          <= 1'b0;
    end else if (enable) begin
      if (accept_start) begin
        vec.tb_mode   <= cfg_mode;
        vec.tb_format <= cfg_format;
        n_last_q      <= cfg_n_last;
        vec_count     <= 32'd0;
        done          <= 1'b0;
      end
      if (state_q == ST_LOAD) vec.out_valid <= 1'b1;
      if (xfer) begin
        vec_count <= vec_count + 32'd1;
        if (last_xfer) begin
          vec.out_valid <= 1'b0;
          done          <= 1'b1;
        end
      end
    end
  end

  // Vector payload: loaded from the current LFSR state in LOAD, and from
  // the stepped state on each transfer so the next vector has no bubble.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      vec.tb_n     <= '0;
      vec.tb_u_n   <= '0;
      vec.tb_v_n   <= '0;
      vec.tb_d_u_n <= BKM_D_ZERO;
      vec.tb_d_v_n <= BKM_D_ZERO;
    end else if (enable) begin
      if (state_q == ST_LOAD) begin
        vec.tb_n     <= '0;
        vec.tb_u_n   <= lfsr_u_q[W-1:0];
        vec.tb_v_n   <= lfsr_v_q[W-1:0];
        vec.tb_d_u_n <= legal_digit(lfsr_u_q[63:62]);
        vec.tb_d_v_n <= legal_digit(lfsr_v_q[63:62]);
      end else if (xfer) begin
        vec.tb_n     <= (vec.tb_n == n_last_q) ? '0 : vec.tb_n + LOG2N'(1);
        vec.tb_u_n   <= lfsr_u_nx[W-1:0];
        vec.tb_v_n   <= lfsr_v_nx[W-1:0];
        vec.tb_d_u_n <= legal_digit(lfsr_u_nx[63:62]);
        vec.tb_d_v_n <= legal_digit(lfsr_v_nx[63:62]);
      end
    end
  end

endmodule

// File: tb/tb_bkm_control_step_stim.sv
// Bench for the BKM step stimulus generator (N_VEC=4, SEED_U=0, SEED_V=2).
module tb_bkm_control_step_stim;

  typedef struct {
    logic [5:0]  n;
    logic [1:0]  du;
    logic [1:0]  dv;
    logic [63:0] u;
    logic [63:0] v;
  } vec_t;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        enable = 1'b1;
  logic        start = 1'b0;
  logic        cfg_mode = 1'b0;
  logic [1:0]  cfg_format = 2'b00;
  logic [5:0]  cfg_n_last = 6'd0;
  logic [31:0] vec_count;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  vec_t run1[4];
  vec_t run2[4];

  bkm_control_step_stim_if #(.W(64), .LOG2N(6)) vif ();

  bkm_control_step_stim #(
    .W(64), .LOG2N(6), .N_VEC(4), .SEED_U(64'h0), .SEED_V(64'h2)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .enable     (enable),
    .start      (start),
    .cfg_mode   (cfg_mode),
    .cfg_format (cfg_format),
    .cfg_n_last (cfg_n_last),
    .vec        (vif),
    .vec_count  (vec_count),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] gstep(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? 64'hD800000000000000 : 64'h0);
  endfunction

  function automatic logic [1:0] dmap(input logic [1:0] r);
    return (r == 2'b10) ? 2'b00 : r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input vec_t e);
    chk({tag, "_valid"}, 64'(vif.out_valid), 64'd1);
    chk({tag, "_n"},     64'(vif.tb_n),      64'(e.n));
    chk({tag, "_u"},     vif.tb_u_n,         e.u);
    chk({tag, "_v"},     vif.tb_v_n,         e.v);
    chk({tag, "_du"},    64'(vif.tb_d_u_n),  64'(e.du));
    chk({tag, "_dv"},    64'(vif.tb_d_v_n),  64'(e.dv));
  endtask

  initial begin
    logic [63:0] m_u, m_v;
    logic [3:0]  seen_u, seen_v;
    int          nacc, cyc;

    // Hand-derived vectors: u from seed 0 (->1), v from seed 2, n_last=2
    run1[0] = '{n: 6'd0, du: 2'b00, dv: 2'b00, u: 64'h1,                v: 64'h2};
    run1[1] = '{n: 6'd1, du: 2'b11, dv: 2'b00, u: 64'hD800000000000000, v: 64'h1};
    run1[2] = '{n: 6'd2, du: 2'b01, dv: 2'b11, u: 64'h6C00000000000000, v: 64'hD800000000000000};
    run1[3] = '{n: 6'd0, du: 2'b00, dv: 2'b01, u: 64'h3600000000000000, v: 64'h6C00000000000000};
    // Second run continues the LFSRs (four steps further)
    run2[0] = '{n: 6'd0, du: 2'b00, dv: 2'b00, u: 64'h1B00000000000000, v: 64'h3600000000000000};
    run2[1] = '{n: 6'd1, du: 2'b00, dv: 2'b00, u: 64'h0D80000000000000, v: 64'h1B00000000000000};
    run2[2] = '{n: 6'd2, du: 2'b00, dv: 2'b00, u: 64'h06C0000000000000, v: 64'h0D80000000000000};
    run2[3] = '{n: 6'd0, du: 2'b00, dv: 2'b00, u: 64'h0360000000000000, v: 64'h06C0000000000000};

    vif.out_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(vif.out_valid), 64'd0);
    chk("rst_busy",  64'(busy),          64'd0);
    chk("rst_done",  64'(done),          64'd0);
    chk("rst_count", 64'(vec_count),     64'd0);
    chk("rst_u",     vif.tb_u_n,         64'd0);
    chk("rst_n",     64'(vif.tb_n),      64'd0);
    arst = 1'b0;

    // Run 1: ready tied high, n_last=2
    cfg_mode = 1'b1; cfg_format = 2'b10; cfg_n_last = 6'd2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("load_busy",   64'(busy),          64'd1);
    chk("load_valid",  64'(vif.out_valid), 64'd0);
    chk("load_mode",   64'(vif.tb_mode),   64'd1);
    chk("load_format", 64'(vif.tb_format), 64'd2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_vec($sformatf("r1v%0d", k), run1[k]);
      chk($sformatf("r1v%0d_count", k), 64'(vec_count), 64'(k));
    end
    @(negedge clk);
    chk("r1_done",  64'(done),          64'd1);
    chk("r1_busy",  64'(busy),          64'd0);
    chk("r1_valid", 64'(vif.out_valid), 64'd0);
    chk("r1_count", 64'(vec_count),     64'd4);

    // Run 2: restart continues LFSRs; 5-cycle stall on vector 1
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("r2_done_cleared", 64'(done), 64'd0);
    @(negedge clk);
    chk_vec("r2v0", run2[0]);
    @(negedge clk);
    chk_vec("r2v1", run2[1]);
    vif.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_vec($sformatf("stall%0d", i), run2[1]);
      chk($sformatf("stall%0d_count", i), 64'(vec_count), 64'd1);
    end
    vif.out_ready = 1'b1;
    @(negedge clk);
    chk_vec("r2v2", run2[2]);
    chk("r2v2_count", 64'(vec_count), 64'd2);
    @(negedge clk);
    chk_vec("r2v3", run2[3]);
    @(negedge clk);
    chk("r2_done",  64'(done),      64'd1);
    chk("r2_count", 64'(vec_count), 64'd4);

    // start while enable=0 is ignored
    enable = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0; enable = 1'b1;
    chk("en0_start_busy", 64'(busy), 64'd0);
    chk("en0_start_done", 64'(done), 64'd1);

    // Run 3: enable low for 3 cycles with ready high
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("r3_count1", 64'(vec_count), 64'd1);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_count", i), 64'(vec_count),     64'd1);
      chk($sformatf("hold%0d_valid", i), 64'(vif.out_valid), 64'd1);
    end
    enable = 1'b1;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("r3_done",  64'(done),      64'd1);
    chk("r3_count", 64'(vec_count), 64'd4);

    // Run 4: arst on the third RUN cycle
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_arst_n", 64'(vif.tb_n), 64'd2);
    #2 arst = 1'b1;
    #1;
    chk("arst_valid", 64'(vif.out_valid), 64'd0);
    chk("arst_busy",  64'(busy),          64'd0);
    chk("arst_n",     64'(vif.tb_n),      64'd0);
    chk("arst_count", 64'(vec_count),     64'd0);
    @(negedge clk);
    arst = 1'b0; cfg_n_last = 6'd0; vif.out_ready = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("reseed_u", vif.tb_u_n, 64'h1);
    chk("reseed_v", vif.tb_v_n, 64'h2);
    vif.out_ready = 1'b1;

    // Long sweep: 10000 vectors over repeated runs, n_last=0
    m_u = 64'h1; m_v = 64'h2;
    seen_u = 4'b0; seen_v = 4'b0;
    nacc = 0; cyc = 0;
    while (nacc < 10000 && cyc < 40000) begin
      start = 1'b0;
      if (vif.out_valid) begin
        chk("sweep_u", vif.tb_u_n, m_u);
        chk("sweep_v", vif.tb_v_n, m_v);
        chk("sweep_n", 64'(vif.tb_n), 64'd0);
        chk("sweep_digits", {60'd0, vif.tb_d_u_n, vif.tb_d_v_n},
            {60'd0, dmap(m_u[63:62]), dmap(m_v[63:62])});
        chk("sweep_legal", 64'((vif.tb_d_u_n != 2'b10) && (vif.tb_d_v_n != 2'b10)), 64'd1);
        chk("sweep_nonzero", 64'((vif.tb_u_n != 64'd0) && (vif.tb_v_n != 64'd0)), 64'd1);
        seen_u[vif.tb_d_u_n] = 1'b1;
        seen_v[vif.tb_d_v_n] = 1'b1;
        m_u = gstep(m_u);
        m_v = gstep(m_v);
        nacc++;
      end else if (done) begin
        start = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("sweep_total", 64'(nacc), 64'd10000);
    chk("seen_u_digits", 64'(seen_u & 4'b1011), 64'hB);
    chk("seen_v_digits", 64'(seen_v & 4'b1011), 64'hB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
